// File: rtl/vga_stream_pkg.sv
// Shared stream layout and 800x600 timing defaults for vga_stream_gen.
package vga_stream_pkg;

  localparam int STREAM_W = 26;

  // Bit positions inside the 26-bit RGB stream word
  localparam int ACTIVE_BIT = 0;
  localparam int VS_BIT     = 1;
  localparam int HS_BIT     = 2;
  localparam int YC_LSB     = 3;
  localparam int YC_MSB     = 12;
  localparam int XC_LSB     = 13;
  localparam int XC_MSB     = 22;
  localparam int R_BIT      = 23;
  localparam int G_BIT      = 24;
  localparam int B_BIT      = 25;
  localparam int RGB_LSB    = 23;
  localparam int RGB_MSB    = 25;
  localparam int VGA_LSB    = 0;
  localparam int VGA_MSB    = 2;

  localparam int H_VISIBLE_DEF = 800;
  localparam int H_FP_DEF      = 56;
  localparam int H_SYNC_DEF    = 120;
  localparam int H_BP_DEF      = 64;
  localparam int V_VISIBLE_DEF = 600;
  localparam int V_FP_DEF      = 37;
  localparam int V_SYNC_DEF    = 6;
  localparam int V_BP_DEF      = 23;

  // Field order mirrors the bit positions above, MSB first
  typedef struct packed {
    logic [2:0] rgb;
    logic [9:0] xc;
    logic [9:0] yc;
    logic       hs;
    logic       vs;
    logic       active;
  } stream_t;

endpackage

// File: rtl/vga_stream_gen.sv
// VGA timing generator emitting a registered 26-bit pixel stream word per px_clk.
// Optional macro BORDER_EN paints a white one-pixel frame around the visible area.
module vga_stream_gen
  import vga_stream_pkg::*;
#(
  parameter int   H_VISIBLE = H_VISIBLE_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_VISIBLE = V_VISIBLE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter logic SYNC_POL  = 1'b1
) (
  input  logic        px_clk,
  input  logic        rst_n,
  input  logic [2:0]  bg_rgb,
  output logic [25:0] strRGB_o,
  output logic        frame_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HC_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] HC_VIS   = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  VC_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VC_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
`ifdef BORDER_EN
  localparam logic [10:0] HC_VIS_LAST = 11'(H_VISIBLE - 1);
  localparam logic [9:0]  VC_VIS_LAST = 10'(V_VISIBLE - 1);
`endif

  logic [10:0] hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  stream_t     pix_q, pix_d;
  logic        frame_q, frame_d;
  logic        hc_wrap;
  logic        active;

  always_comb begin
    hc_wrap = (hc_q == HC_LAST);
    hc_d    = hc_wrap ? 11'd0 : hc_q + 11'd1;
    vc_d    = vc_q;
    if (hc_wrap) begin
      vc_d = (vc_q == VC_LAST) ? 10'd0 : vc_q + 10'd1;
    end

    // Output word describes the current (hc,vc); it appears one edge later
    active       = (hc_q < HC_VIS) && (vc_q < VC_VIS);
    pix_d        = '0;
    pix_d.active = active;
    pix_d.hs     = ((hc_q >= HS_START) && (hc_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    pix_d.vs     = ((vc_q >= VS_START) && (vc_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
    pix_d.xc     = hc_q[9:0];
    pix_d.yc     = vc_q;
    pix_d.rgb    = active ? bg_rgb : 3'b000;
`ifdef BORDER_EN
    if (active && ((hc_q == 11'd0) || (hc_q == HC_VIS_LAST) ||
                   (vc_q == 10'd0) || (vc_q == VC_VIS_LAST))) begin
      pix_d.rgb = 3'b111;
    end
`endif
    frame_d = (hc_q == 11'd0) && (vc_q == 10'd0);
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q    <= '0;
      vc_q    <= '0;
      pix_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      pix_q   <= pix_d;
      frame_q <= frame_d;
    end
  end

  assign strRGB_o = pix_q;
  assign frame_o  = frame_q;

endmodule
